// File: rtl/clb_ctrl_route_pkg.sv
// Shared select encodings, config field layout and helpers for the CLB control router.
package clb_ctrl_route_pkg;

    localparam int CFG_W = 6;

    localparam logic [1:0] CLKIN_K      = 2'd0;
    localparam logic [1:0] CLKIN_C      = 2'd1;
    localparam logic [1:0] CLKIN_G      = 2'd2;

    localparam logic [1:0] CLKPOL_POS   = 2'd0;
    localparam logic [1:0] CLKPOL_NEG   = 2'd1;
    localparam logic [1:0] CLKPOL_NONE  = 2'd2;

    localparam logic [1:0] RIN_D        = 2'd0;
    localparam logic [1:0] RIN_G        = 2'd1;
    localparam logic [1:0] RIN_NONE     = 2'd2;

    localparam logic [1:0] SEL_RESERVED = 2'd3;

    localparam int CFG_CLKIN_LSB  = 0;
    localparam int CFG_CLKPOL_LSB = 2;
    localparam int CFG_RIN_LSB    = 4;

    // Field order matches the cfg_wdata bit layout, MSB first.
    typedef struct packed {
        logic [1:0] rin;
        logic [1:0] clkpol;
        logic [1:0] clkin;
    } cfg_t;

    function automatic logic cfg_has_reserved(input cfg_t c);
        return (c.clkin == SEL_RESERVED) || (c.clkpol == SEL_RESERVED) ||
               (c.rin == SEL_RESERVED);
    endfunction

endpackage

// File: rtl/clb_ctrl_route_mux3.sv
// Three-input select with the reserved code folding back onto input 0.
module clb_ctrl_route_mux3
    import clb_ctrl_route_pkg::*;
(
    input  logic [1:0] sel,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    output logic       out
);

    // Select one of three inputs; the reserved code behaves as code 0.
    always_comb begin
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/clb_ctrl_route.sv
// CLB storage-element control router: clock source, clock polarity and reset source muxes.
// Optional macro CLB_CTRL_ROUTE_READBACK_EN adds the cfg_rdata readback port.
module clb_ctrl_route
    import clb_ctrl_route_pkg::*;
#(
    parameter logic [1:0] CLKIN_RST  = 2'd0,
    parameter logic [1:0] CLKPOL_RST = 2'd0,
    parameter logic [1:0] RIN_RST    = 2'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [CFG_W-1:0] cfg_wdata,
    input  logic             K,
    input  logic             C,
    input  logic             D,
    input  logic             G,
    output logic             clk_sig,
    output logic             clk_in,
    output logic             r_in,
    output logic             cfg_err
`ifdef CLB_CTRL_ROUTE_READBACK_EN
    ,
    output logic [CFG_W-1:0] cfg_rdata
`endif
);

    localparam cfg_t CFG_RST = '{rin: RIN_RST, clkpol: CLKPOL_RST, clkin: CLKIN_RST};

    cfg_t cfg_d;
    cfg_t cfg_q;
    logic err_d;
    logic err_q;
    logic clk_sig_n_s;

    // Next-state for the select register and the sticky reserved-code flag.
    always_comb begin
        cfg_d = cfg_q;
        err_d = err_q;
        if (cfg_we) begin
            cfg_d = cfg_t'(cfg_wdata);
            err_d = err_q | cfg_has_reserved(cfg_t'(cfg_wdata));
        end else begin
            cfg_d = cfg_q;
            err_d = err_q;
        end
    end

    // Config register with asynchronous reset to the parameterised defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= CFG_RST;
            err_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            err_q <= err_d;
        end
    end

    assign cfg_err     = err_q;
    assign clk_sig_n_s = ~clk_sig;

`ifdef CLB_CTRL_ROUTE_READBACK_EN
    assign cfg_rdata = cfg_q;
`endif

    clb_ctrl_route_mux3 u_clkin_mux (
        .sel (cfg_q.clkin),
        .in0 (K),
        .in1 (C),
        .in2 (G),
        .out (clk_sig)
    );

    clb_ctrl_route_mux3 u_clkpol_mux (
        .sel (cfg_q.clkpol),
        .in0 (clk_sig),
        .in1 (clk_sig_n_s),
        .in2 (1'b0),
        .out (clk_in)
    );

    clb_ctrl_route_mux3 u_rin_mux (
        .sel (cfg_q.rin),
        .in0 (D),
        .in1 (G),
        .in2 (1'b0),
        .out (r_in)
    );

endmodule

// File: tb/tb_clb_ctrl_route.sv
// Directed plus randomized bench for clb_ctrl_route against a field-level reference model.
module tb_clb_ctrl_route;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [5:0] cfg_wdata;
    logic       K, C, D, G;
    logic       clk_sig, clk_in, r_in, cfg_err;
`ifdef CLB_CTRL_ROUTE_READBACK_EN
    logic [5:0] cfg_rdata;
`endif

    int n_total;
    int n_pass;

    // Reference model state: the three select fields and the sticky error.
    int   m_clkin, m_clkpol, m_rin;
    logic m_err;

    clb_ctrl_route dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_wdata (cfg_wdata),
        .K         (K),
        .C         (C),
        .D         (D),
        .G         (G),
        .clk_sig   (clk_sig),
        .clk_in    (clk_in),
        .r_in      (r_in),
        .cfg_err   (cfg_err)
`ifdef CLB_CTRL_ROUTE_READBACK_EN
        ,
        .cfg_rdata (cfg_rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic pick(input int sel, input logic a, input logic b, input logic c);
        logic v[3];
        v[0] = a;
        v[1] = b;
        v[2] = c;
        return (sel > 2) ? v[0] : v[sel];
    endfunction

    task automatic model_reset();
        m_clkin  = 0;
        m_clkpol = 0;
        m_rin    = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_write(input logic [5:0] w);
        m_clkin  = int'(w[1:0]);
        m_clkpol = int'(w[3:2]);
        m_rin    = int'(w[5:4]);
        if (m_clkin == 3 || m_clkpol == 3 || m_rin == 3) m_err = 1'b1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        logic e_sig;
        e_sig = pick(m_clkin, K, C, G);
        check_bit({tag, ".clk_sig"}, clk_sig, e_sig);
        check_bit({tag, ".clk_in"},  clk_in,  pick(m_clkpol, e_sig, ~e_sig, 1'b0));
        check_bit({tag, ".r_in"},    r_in,    pick(m_rin, D, G, 1'b0));
        check_bit({tag, ".cfg_err"}, cfg_err, m_err);
`ifdef CLB_CTRL_ROUTE_READBACK_EN
        n_total++;
        assert (cfg_rdata === {2'(m_rin), 2'(m_clkpol), 2'(m_clkin)}) n_pass++;
        else $error("FAIL %s.cfg_rdata observed=%b expected=%b", tag, cfg_rdata,
                    {2'(m_rin), 2'(m_clkpol), 2'(m_clkin)});
`endif
    endtask

    task automatic set_in(input logic k, input logic c, input logic d, input logic g);
        K = k; C = c; D = d; G = g;
        #1;
    endtask

    task automatic do_write(input logic [5:0] w);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_wdata = w;
        @(posedge clk);
        model_write(w);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_wdata = 6'd0;
        model_reset();

        // Reset defaults
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        check_all("reset");
        check_bit("reset.const_clk_sig", clk_sig, 1'b1);
        check_bit("reset.const_r_in", r_in, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Clock source C then G
        do_write(6'b000001);
        set_in(1'b0, 1'b0, 1'b0, 1'b0); check_all("src_c0");
        set_in(1'b0, 1'b1, 1'b0, 1'b0); check_all("src_c1");
        check_bit("src_c1.const", clk_sig, 1'b1);
        do_write(6'b000010);
        set_in(1'b0, 1'b0, 1'b0, 1'b1); check_all("src_g1");
        set_in(1'b1, 1'b1, 1'b0, 1'b0); check_all("src_g0");

        // Polarity inverted then ground
        do_write(6'b000100);
        set_in(1'b1, 1'b0, 1'b0, 1'b0); check_all("pol_neg_k1");
        check_bit("pol_neg_k1.const", clk_in, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0); check_all("pol_neg_k0");
        do_write(6'b001000);
        set_in(1'b1, 1'b0, 1'b0, 1'b0); check_all("pol_none_k1");
        set_in(1'b0, 1'b0, 1'b0, 1'b0); check_all("pol_none_k0");

        // Reset source
        do_write(6'b010000);
        set_in(1'b0, 1'b0, 1'b0, 1'b1); check_all("rin_g");
        do_write(6'b100000);
        set_in(1'b0, 1'b0, 1'b1, 1'b1); check_all("rin_none");
        do_write(6'b000000);
        set_in(1'b0, 1'b0, 1'b1, 1'b0); check_all("rin_d");

        // Reserved code sets the sticky error; only rst_n clears it
        do_write(6'b000011);
        set_in(1'b1, 1'b0, 1'b0, 1'b1); check_all("rsv_k1");
        check_bit("rsv.const_err", cfg_err, 1'b1);
        set_in(1'b0, 1'b1, 1'b0, 1'b1); check_all("rsv_k0");
        do_write(6'b000001);
        check_all("rsv_sticky");
        @(negedge clk);
        rst_n = 1'b0; #1; model_reset();
        check_all("rsv_cleared");
        rst_n = 1'b1;

        // Asynchronous reset between edges
        do_write(6'b100110);
        set_in(1'b1, 1'b0, 1'b1, 1'b1); check_all("pre_async");
        #2;
        rst_n = 1'b0; #1; model_reset();
        check_all("async_rst");

        // Write on an edge while reset is held is lost
        @(negedge clk);
        cfg_we = 1'b1; cfg_wdata = 6'b010111;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check_all("rst_wins");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 300; i++) begin
            logic [5:0] w;
            logic       we;
            @(negedge clk);
            w  = 6'($urandom_range(0, 63));
            we = 1'($urandom_range(0, 1));
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_all("rnd_mid");
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0; #1; model_reset();
                check_all("rnd_rst");
                rst_n = 1'b1;
            end
            cfg_we = we; cfg_wdata = w;
            @(posedge clk);
            if (we) model_write(w);
            #1;
            cfg_we = 1'b0;
            check_all("rnd_post");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
